fifo_sync: RTL and testbench

Single-clock, parameterised first-in/first-out buffer with registered read data and full/empty status flags. It decouples a producer and a consumer that share one clock domain. Writes into a full FIFO and reads from an empty FIFO are dropped without corrupting contents. It is the synchronous counterpart of the team's asynchronous FIFO.

---
 rtl/fifo_sync_pkg.sv | 37 +++
 rtl/fifo_sync_if.sv | 49 ++++
 rtl/fifo_sync_mem.sv | 52 +++++
 rtl/fifo_sync.sv | 110 +++++++++++
 tb/tb_fifo_sync.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_sync_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sync_pkg
// Shared constants and helpers for the single-clock FIFO.
//   DEPTH_DEF / WIDTH_DEF : default geometry (8 entries of 8 bits)
//   PTR_MAX_W             : width the flag helpers work in; pointers are
//                           zero-extended to it before comparison
//   ptr_width()           : clog2(DEPTH)+1, the extra MSB being the wrap bit
//   ptrs_empty()/ptrs_full(): flag decode from the write/read pointers
// -----------------------------------------------------------------------------
package fifo_sync_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int WIDTH_DEF = 8;
    localparam int PTR_MAX_W = 32;

    localparam logic [PTR_MAX_W-1:0] PTR_LSB_ONE = {{(PTR_MAX_W-1){1'b0}}, 1'b1};

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Empty when both pointers, wrap bit included, are identical.
    function automatic logic ptrs_empty(input logic [PTR_MAX_W-1:0] wr_ptr,
                                        input logic [PTR_MAX_W-1:0] rd_ptr);
        return (wr_ptr == rd_ptr);
    endfunction

    // Full when the address bits match and only the wrap bit (bit addr_w)
    // differs, i.e. the writer is exactly one lap ahead of the reader.
    function automatic logic ptrs_full(input logic [PTR_MAX_W-1:0] wr_ptr,
                                       input logic [PTR_MAX_W-1:0] rd_ptr,
                                       input int                   addr_w);
        return ((wr_ptr ^ rd_ptr) == (PTR_LSB_ONE << addr_w));
    endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// -----------------------------------------------------------------------------
// fifo_sync_if
// Request/data/status bundle between a producer/consumer and fifo_sync.
//   wrEn, rdEn : write / read requests
//   dataIn     : write data
//   dataOut    : registered read data
//   empty/full : occupancy flags
//   overflow / underflow : sticky drop indicators, present only when
//                          FIFO_SYNC_ERR_EN is defined
// Modports: master = user side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface fifo_sync_if
    import fifo_sync_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             wrEn;
    logic             rdEn;
    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] dataOut;
    logic             empty;
    logic             full;
`ifdef FIFO_SYNC_ERR_EN
    logic             overflow;
    logic             underflow;

    modport master (
        output wrEn, rdEn, dataIn,
        input  dataOut, empty, full, overflow, underflow
    );

    modport slave (
        input  wrEn, rdEn, dataIn,
        output dataOut, empty, full, overflow, underflow
    );
`else
    modport master (
        output wrEn, rdEn, dataIn,
        input  dataOut, empty, full
    );

    modport slave (
        input  wrEn, rdEn, dataIn,
        output dataOut, empty, full
    );
`endif

endinterface

// File: rtl/fifo_sync_mem.sv
// -----------------------------------------------------------------------------
// fifo_sync_mem
// DEPTH x WIDTH register array with one write port and one registered read
// port. The array itself is never reset; only the read data register is,
// so that the FIFO output reads zero straight out of reset.
// Ports:
//   i_clk      clock
//   i_rst_n    async active-low reset (read data register only)
//   i_wr_en    write strobe (already qualified by !full)
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read strobe (already qualified by !empty)
//   i_rd_addr  read address
//   o_rd_data  registered read data, holds when i_rd_en is low
// -----------------------------------------------------------------------------
module fifo_sync_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port: storage without reset, contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: one-cycle latency, holds last word between reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= {WIDTH{1'b0}};
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
// Single-clock FIFO with registered read data and combinational full/empty
// flags. Writes while full and reads while empty are dropped without touching
// pointers, storage or dataOut. No fall-through: a word written into an empty
// FIFO is readable from the following cycle.
// Ports:
//   clk   clock, all state changes on the rising edge
//   rstN  async active-low reset: pointers cleared, dataOut = 0
//   bus   fifo_sync_if.slave (wrEn, rdEn, dataIn, dataOut, empty, full and,
//         with FIFO_SYNC_ERR_EN, sticky overflow/underflow)
// Build option: define FIFO_SYNC_ERR_EN to add the overflow/underflow flags.
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rstN,
    fifo_sync_if.slave  bus
);

    localparam int PW  = ptr_width(DEPTH);
    localparam int AW  = PW - 1;
    localparam int PAD = PTR_MAX_W - PW;

    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_wr_acc;
    logic w_rd_acc;

    // Flags straight from the current pointers, so they follow a pointer
    // update in the same cycle.
    assign w_empty = ptrs_empty({{PAD{1'b0}}, r_wr_ptr}, {{PAD{1'b0}}, r_rd_ptr});
    assign w_full  = ptrs_full({{PAD{1'b0}}, r_wr_ptr}, {{PAD{1'b0}}, r_rd_ptr}, AW);

    // Accept decisions use the pre-edge flags: a write into a full FIFO is
    // dropped even if a read frees a slot on the same edge, and a read of an
    // empty FIFO is dropped even if a write lands on the same edge.
    assign w_wr_acc = bus.wrEn & ~w_full;
    assign w_rd_acc = bus.rdEn & ~w_empty;

    // Write pointer; natural binary overflow gives the modulo-2*DEPTH wrap.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr <= {PW{1'b0}};
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
    end

    // Read pointer; same wrap behaviour as the write pointer.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rd_ptr <= {PW{1'b0}};
        end else if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    fifo_sync_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (bus.dataIn),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (bus.dataOut)
    );

    assign bus.empty = w_empty;
    assign bus.full  = w_full;

`ifdef FIFO_SYNC_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky drop indicators; only reset clears them.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wrEn & w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rdEn & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync
// Self-checking bench for fifo_sync. A queue-based reference model predicts
// accepted writes/reads; every word the model reads is pushed into a
// scoreboard queue that a separate negedge monitor pops and compares against
// dataOut. Flags are compared every cycle against the model occupancy.
// -----------------------------------------------------------------------------
module tb_fifo_sync;
    import fifo_sync_pkg::*;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic clk;
    logic rstN;

    fifo_sync_if #(.WIDTH(WIDTH)) bus ();

    fifo_sync #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             ovf_m = 1'b0;
    logic             unf_m = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus; the model applies the edge using pre-edge occupancy.
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        int sz;
        bus.wrEn   = w;
        bus.rdEn   = r;
        bus.dataIn = d;
        @(posedge clk);
        sz = model_q.size();
        if (w && sz == DEPTH) ovf_m = 1'b1;
        if (r && sz == 0)     unf_m = 1'b1;
        if (r && sz > 0)      exp_q.push_back(model_q.pop_front());
        if (w && sz < DEPTH)  model_q.push_back(d);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_empty"},   32'(bus.empty),   32'd1);
        chk({tag, "_full"},    32'(bus.full),    32'd0);
        chk({tag, "_dataOut"}, 32'(bus.dataOut), 32'd0);
`ifdef FIFO_SYNC_ERR_EN
        chk({tag, "_overflow"},  32'(bus.overflow),  32'd0);
        chk({tag, "_underflow"}, 32'(bus.underflow), 32'd0);
`endif
    endtask

    // Reset asserted a few ns after an edge, checked before the next edge.
    task automatic reset_mid_cycle(input string tag);
        bus.wrEn = 1'b0;
        bus.rdEn = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        check_reset_values(tag);
        model_q.delete();
        exp_q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    // Monitor: pops the scoreboard when a read was accepted on the last edge.
    logic             pend_rd;
    logic [WIDTH-1:0] held;
    always @(negedge clk) begin
        if (!rstN) begin
            pend_rd = 1'b0;
            held    = '0;
        end else begin
            if (pend_rd) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got 0x%0h expected no read at %0t", bus.dataOut, $time);
                end else begin
                    held = exp_q.pop_front();
                    chk("dataOut", 32'(bus.dataOut), 32'(held));
                end
            end else begin
                chk("dataOut_hold", 32'(bus.dataOut), 32'(held));
            end
            chk("empty", 32'(bus.empty), 32'(model_q.size() == 0));
            chk("full",  32'(bus.full),  32'(model_q.size() == DEPTH));
`ifdef FIFO_SYNC_ERR_EN
            chk("overflow",  32'(bus.overflow),  32'(ovf_m));
            chk("underflow", 32'(bus.underflow), 32'(unf_m));
`endif
            pend_rd = bus.rdEn && !bus.empty;
        end
    end

    initial begin
        int pw, pr;
        rstN       = 1'b0;
        bus.wrEn   = 1'b0;
        bus.rdEn   = 1'b0;
        bus.dataIn = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        rstN = 1'b1;

        // Underflow: reads on an empty FIFO leave dataOut at 0.
        step(1'b0, 1'b1, 8'hAA);
        step(1'b0, 1'b1, 8'hBB);
        step(1'b0, 1'b0, 8'h00);

        // Overfill: 12 writes, last 4 dropped; then 8 reads in order.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 8; i++)  step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Mid-operation reset discards stored words and nonzero dataOut.
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b0, 8'hC0 + 8'(i));
        reset_mid_cycle("mid");

        // Wrap-around across the pointer wrap bit.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h10 + 8'(k * 5 + i));
            for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
        end
        step(1'b0, 1'b0, 8'h00);

        // Simultaneous read/write with 4 entries held for 10 cycles.
        for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 8'h40 + 8'(i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'h50 + 8'(i));
        for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Full with both requests: only the read happens.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
        step(1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Empty with both requests: only the write happens, no fall-through.
        step(1'b1, 1'b1, 8'h99);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Random traffic, write-heavy then read-heavy.
        for (int i = 0; i < 400; i++) begin
            pw = (i < 200) ? 70 : 35;
            pr = (i < 200) ? 35 : 70;
            step(($urandom_range(0, 99) < pw) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0,
                 8'($urandom));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("model_empty",        32'(model_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
